fetch_inst_sender: RTL and testbench

- Transmit end of the backend fetch interface: drives `o_inst_vld`/`o_inst_*` into the control block's fetch instruction buffer and honours its stall.
- Accepts predecoded fetch blocks (start PC, FTQ index, up to BLK_INSTS 32-bit instructions) from the frontend and queues them.
- Slices each block into FETCH_WIDTH-wide groups and drops all in-flight state on backend squash.

---
 rtl/fetch_inst_sender_if.sv | 36 +++
 rtl/fetch_inst_sender.sv | 211 +++++++++++++++++++++
 tb/tb_fetch_inst_sender.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_inst_sender_if.sv
// Fetch-block input and instruction-group output bundle of fetch_inst_sender.
// slave: the sender itself; master: frontend/backend side driving it.
interface fetch_inst_sender_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int BLK_INSTS   = 8,
    parameter int FTQIDX_W    = 4,
    parameter int XLEN        = 64
);
    localparam int OFFW = $clog2(BLK_INSTS);

    logic                        i_blk_vld;
    logic                        o_blk_rdy;
    logic [XLEN-1:0]             i_blk_startpc;
    logic [FTQIDX_W-1:0]         i_blk_ftqIdx;
    logic [OFFW:0]               i_blk_cnt;
    logic [32*BLK_INSTS-1:0]     i_blk_insts;
    logic                        i_stall;
    logic                        i_squash_vld;
    logic [FETCH_WIDTH-1:0]      o_inst_vld;
    logic [32*FETCH_WIDTH-1:0]   o_inst;
    logic [XLEN*FETCH_WIDTH-1:0] o_pc;
    logic [FTQIDX_W-1:0]         o_ftqIdx;
    logic [OFFW*FETCH_WIDTH-1:0] o_ftqOffset;

    modport slave (
        input  i_blk_vld, i_blk_startpc, i_blk_ftqIdx, i_blk_cnt,
        input  i_blk_insts, i_stall, i_squash_vld,
        output o_blk_rdy, o_inst_vld, o_inst, o_pc, o_ftqIdx, o_ftqOffset
    );

    modport master (
        output i_blk_vld, i_blk_startpc, i_blk_ftqIdx, i_blk_cnt,
        output i_blk_insts, i_stall, i_squash_vld,
        input  o_blk_rdy, o_inst_vld, o_inst, o_pc, o_ftqIdx, o_ftqOffset
    );
endinterface

// File: rtl/fetch_inst_sender.sv
// Queues fetch blocks and slices them into FETCH_WIDTH groups for the backend.
// Optional perf counters enabled by defining FETCH_SENDER_PERF_EN.
module fetch_inst_sender #(
    parameter int FETCH_WIDTH   = 4,
    parameter int BLK_INSTS     = 8,
    parameter int QDEPTH        = 2,
    parameter int FTQIDX_W      = 4,
    parameter int XLEN          = 64,
    parameter int SQUASH_BUBBLE = 2
) (
    input  logic clk,
    input  logic rst,
    fetch_inst_sender_if.slave bus
`ifdef FETCH_SENDER_PERF_EN
    ,
    output logic [31:0] o_perf_sent,
    output logic [31:0] o_perf_stall
`endif
);
    localparam int OFFW = $clog2(BLK_INSTS);
    localparam int CW   = OFFW + 1;
    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int NW   = $clog2(QDEPTH + 1);
    localparam int BW   = (SQUASH_BUBBLE > 1) ? $clog2(SQUASH_BUBBLE) : 1;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   bub_q, bub_d;

    logic [XLEN-1:0]         q_pc_q    [QDEPTH];
    logic [FTQIDX_W-1:0]     q_ftq_q   [QDEPTH];
    logic [CW-1:0]           q_cnt_q   [QDEPTH];
    logic [32*BLK_INSTS-1:0] q_insts_q [QDEPTH];

    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [NW-1:0] count_q;
    logic [CW-1:0] cur_q, cur_d;

    logic [FETCH_WIDTH-1:0]      vld_q, vld_d;
    logic [32*FETCH_WIDTH-1:0]   inst_q, inst_d;
    logic [XLEN*FETCH_WIDTH-1:0] pc_q, pc_d;
    logic [FTQIDX_W-1:0]         ftq_q, ftq_d;
    logic [OFFW*FETCH_WIDTH-1:0] off_q, off_d;

    logic [CW-1:0] blk_cnt;
    logic [CW-1:0] rem;
    logic [CW-1:0] n;
    logic [CW-1:0] idx;
    logic          push, pop, load;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign blk_cnt = (bus.i_blk_cnt > CW'(BLK_INSTS)) ? CW'(BLK_INSTS)
                                                      : bus.i_blk_cnt;

    assign bus.o_blk_rdy = rst && (state_q == RUN)
                        && (count_q < NW'(QDEPTH)) && !bus.i_squash_vld;

    assign bus.o_inst_vld  = vld_q;
    assign bus.o_inst      = inst_q;
    assign bus.o_pc        = pc_q;
    assign bus.o_ftqIdx    = ftq_q;
    assign bus.o_ftqOffset = off_q;

    // State register for the squash bubble FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    // Squash enters FLUSH and (re)loads the bubble counter
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        if (bus.i_squash_vld) begin
            state_d = FLUSH;
            bub_d   = BW'(SQUASH_BUBBLE - 1);
        end else if (state_q == FLUSH) begin
            if (bub_q == '0) state_d = RUN;
            else             bub_d   = bub_q - 1'b1;
        end
    end

    // Slice the head block at the cursor into the next output group
    always_comb begin
        load   = (vld_q == '0) || !bus.i_stall;
        push   = bus.i_blk_vld && bus.o_blk_rdy && (blk_cnt != '0);
        pop    = 1'b0;
        rem    = q_cnt_q[rd_ptr_q] - cur_q;
        n      = (rem > CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : rem;
        idx    = '0;
        cur_d  = cur_q;
        vld_d  = vld_q;
        inst_d = inst_q;
        pc_d   = pc_q;
        ftq_d  = ftq_q;
        off_d  = off_q;
        if (load) begin
            if (count_q != '0) begin
                vld_d  = '0;
                inst_d = '0;
                pc_d   = '0;
                off_d  = '0;
                for (int k = 0; k < FETCH_WIDTH; k++) begin
                    idx = cur_q + CW'(k);
                    if (CW'(k) < n) begin
                        vld_d[k] = 1'b1;
                        inst_d[32*k +: 32] =
                            q_insts_q[rd_ptr_q][32*idx[OFFW-1:0] +: 32];
                        pc_d[XLEN*k +: XLEN] = q_pc_q[rd_ptr_q]
                            + {{(XLEN-CW-2){1'b0}}, idx, 2'b00};
                        off_d[OFFW*k +: OFFW] = idx[OFFW-1:0];
                    end
                end
                ftq_d = q_ftq_q[rd_ptr_q];
                cur_d = cur_q + n;
                if (cur_d == q_cnt_q[rd_ptr_q]) begin
                    pop   = 1'b1;
                    cur_d = '0;
                end
            end else begin
                vld_d = '0;
            end
        end
    end

    // Queue pointers, cursor and output register; squash drops everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cur_q    <= '0;
            vld_q    <= '0;
            inst_q   <= '0;
            pc_q     <= '0;
            ftq_q    <= '0;
            off_q    <= '0;
        end else if (bus.i_squash_vld) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cur_q    <= '0;
            vld_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + NW'(push) - NW'(pop);
            cur_q   <= cur_d;
            vld_q   <= vld_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            ftq_q   <= ftq_d;
            off_q   <= off_d;
        end
    end

    // Block storage, written on accepted non-empty blocks
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]    <= bus.i_blk_startpc;
            q_ftq_q[wr_ptr_q]   <= bus.i_blk_ftqIdx;
            q_cnt_q[wr_ptr_q]   <= blk_cnt;
            q_insts_q[wr_ptr_q] <= bus.i_blk_insts;
        end
    end

`ifdef FETCH_SENDER_PERF_EN
    localparam int FW_W = $clog2(FETCH_WIDTH + 1);

    logic [31:0]     sent_q, stall_q;
    logic [FW_W-1:0] vld_pop;
    logic [32:0]     sent_sum;

    assign o_perf_sent  = sent_q;
    assign o_perf_stall = stall_q;

    // Number of instructions in the current output group
    always_comb begin
        vld_pop = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            vld_pop = vld_pop + FW_W'(vld_q[k]);
        end
        sent_sum = {1'b0, sent_q} + 33'(vld_pop);
    end

    // Saturating transfer and stall counters, untouched by squash
    always_ff @(posedge clk) begin
        if (!rst) begin
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            if (!bus.i_stall) begin
                sent_q <= sent_sum[32] ? '1 : sent_sum[31:0];
            end
            if ((vld_q != '0) && bus.i_stall && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_inst_sender.sv
// Directed testbench for fetch_inst_sender.
// Checks reset, slicing, stall, backpressure, squash, clamp and PC wrap.
module tb_fetch_inst_sender;
    localparam int FW = 4;
    localparam int BI = 8;
    localparam int FQ = 4;
    localparam int XL = 64;

    logic clk = 1'b0;
    logic rst;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_inst_sender_if #(
        .FETCH_WIDTH(FW), .BLK_INSTS(BI), .FTQIDX_W(FQ), .XLEN(XL)
    ) bus ();

`ifdef FETCH_SENDER_PERF_EN
    logic [31:0] perf_sent;
    logic [31:0] perf_stall;
`endif

    fetch_inst_sender #(
        .FETCH_WIDTH(FW), .BLK_INSTS(BI), .QDEPTH(2),
        .FTQIDX_W(FQ), .XLEN(XL), .SQUASH_BUBBLE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_SENDER_PERF_EN
        ,
        .o_perf_sent(perf_sent),
        .o_perf_stall(perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_blk(input logic [63:0] pc, input logic [3:0] ftq,
                           input logic [3:0] cnt, input logic [31:0] base);
        bus.i_blk_vld     = 1'b1;
        bus.i_blk_startpc = pc;
        bus.i_blk_ftqIdx  = ftq;
        bus.i_blk_cnt     = cnt;
        for (int k = 0; k < BI; k++) begin
            bus.i_blk_insts[32*k +: 32] = base + 32'(k);
        end
    endtask

    task automatic idle();
        bus.i_blk_vld = 1'b0;
    endtask

    task automatic chk_grp(input string tag, input logic [3:0] vld,
                           input logic [63:0] pc0, input logic [2:0] off0,
                           input logic [31:0] base, input logic [3:0] ftq);
        logic [63:0] epc;
        logic [2:0]  eoff;
        check({tag, ".vld"}, 64'(bus.o_inst_vld), 64'(vld));
        check({tag, ".ftq"}, 64'(bus.o_ftqIdx), 64'(ftq));
        for (int k = 0; k < FW; k++) begin
            if (vld[k]) begin
                epc  = pc0 + 64'(4 * k);
                eoff = off0 + 3'(k);
                check($sformatf("%s.pc%0d", tag, k),
                      bus.o_pc[XL*k +: XL], epc);
                check($sformatf("%s.off%0d", tag, k),
                      64'(bus.o_ftqOffset[3*k +: 3]), 64'(eoff));
                check($sformatf("%s.inst%0d", tag, k),
                      64'(bus.o_inst[32*k +: 32]),
                      64'(base + 32'(eoff)));
            end
        end
    endtask

    initial begin
        rst               = 1'b0;
        bus.i_blk_vld     = 1'b0;
        bus.i_blk_startpc = '0;
        bus.i_blk_ftqIdx  = '0;
        bus.i_blk_cnt     = '0;
        bus.i_blk_insts   = '0;
        bus.i_stall       = 1'b0;
        bus.i_squash_vld  = 1'b0;
        tick();
        tick();
        check("rst.vld", 64'(bus.o_inst_vld), 64'h0);
        check("rst.pc", bus.o_pc[63:0], 64'h0);
        check("rst.rdy", 64'(bus.o_blk_rdy), 64'h0);
        rst = 1'b1;
        #1;
        check("rst.rdy1", 64'(bus.o_blk_rdy), 64'h1);

        // one 6-instruction block, no stall
        tick();
        set_blk(64'h8000_0000, 4'd3, 4'd6, 32'h1100_0000);
        #1;
        check("t1.rdy", 64'(bus.o_blk_rdy), 64'h1);
        tick();
        idle();
        check("t1.lat", 64'(bus.o_inst_vld), 64'h0);
        tick();
        chk_grp("t1.g0", 4'hF, 64'h8000_0000, 3'd0, 32'h1100_0000, 4'd3);
        tick();
        chk_grp("t1.g1", 4'h3, 64'h8000_0010, 3'd4, 32'h1100_0000, 4'd3);
        tick();
        check("t1.end", 64'(bus.o_inst_vld), 64'h0);

        // 8-instruction block stalled for 3 cycles
        set_blk(64'h1000, 4'd5, 4'd8, 32'h2200_0000);
        tick();
        idle();
        tick();
        chk_grp("t2.g0", 4'hF, 64'h1000, 3'd0, 32'h2200_0000, 4'd5);
        bus.i_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_grp($sformatf("t2.hold%0d", c), 4'hF, 64'h1000, 3'd0,
                    32'h2200_0000, 4'd5);
        end
        bus.i_stall = 1'b0;
        tick();
        chk_grp("t2.g1", 4'hF, 64'h1010, 3'd4, 32'h2200_0000, 4'd5);
        tick();
        check("t2.end", 64'(bus.o_inst_vld), 64'h0);
`ifdef FETCH_SENDER_PERF_EN
        check("t2.pstall", 64'(perf_stall), 64'd3);
        check("t2.psent", 64'(perf_sent), 64'd14);
`endif

        // backpressure: three 2-instruction blocks under constant stall
        bus.i_stall = 1'b1;
        set_blk(64'h3000, 4'd1, 4'd2, 32'h3300_0000);
        #1;
        check("t3.rdyA", 64'(bus.o_blk_rdy), 64'h1);
        tick();
        set_blk(64'h3100, 4'd2, 4'd2, 32'h3400_0000);
        #1;
        check("t3.rdyB", 64'(bus.o_blk_rdy), 64'h1);
        tick();
        set_blk(64'h3200, 4'd3, 4'd2, 32'h3500_0000);
        #1;
        check("t3.rdyC", 64'(bus.o_blk_rdy), 64'h1);
        tick();
        idle();
        #1;
        check("t3.full", 64'(bus.o_blk_rdy), 64'h0);
        chk_grp("t3.A", 4'h3, 64'h3000, 3'd0, 32'h3300_0000, 4'd1);
        tick();
        check("t3.full2", 64'(bus.o_blk_rdy), 64'h0);
        bus.i_stall = 1'b0;
        #1;
        check("t3.full3", 64'(bus.o_blk_rdy), 64'h0);
        tick();
        check("t3.rec", 64'(bus.o_blk_rdy), 64'h1);
        chk_grp("t3.B", 4'h3, 64'h3100, 3'd0, 32'h3400_0000, 4'd2);
        tick();
        chk_grp("t3.C", 4'h3, 64'h3200, 3'd0, 32'h3500_0000, 4'd3);
        tick();
        check("t3.end", 64'(bus.o_inst_vld), 64'h0);

        // squash with stall and enqueue mid-block
        set_blk(64'h4000, 4'd6, 4'd8, 32'h4400_0000);
        tick();
        idle();
        tick();
        check("t4.g0", 64'(bus.o_inst_vld), 64'hF);
        bus.i_stall      = 1'b1;
        bus.i_squash_vld = 1'b1;
        set_blk(64'h4800, 4'd7, 4'd4, 32'h4800_0000);
        #1;
        check("t4.rdy0", 64'(bus.o_blk_rdy), 64'h0);
        tick();
        bus.i_squash_vld = 1'b0;
        #1;
        check("t4.vld", 64'(bus.o_inst_vld), 64'h0);
        check("t4.rdy1", 64'(bus.o_blk_rdy), 64'h0);
        tick();
        check("t4.rdy2", 64'(bus.o_blk_rdy), 64'h0);
        idle();
        bus.i_stall = 1'b0;
        tick();
        check("t4.rdy3", 64'(bus.o_blk_rdy), 64'h1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("t4.drop%0d", c), 64'(bus.o_inst_vld), 64'h0);
        end

        // empty block then a single-instruction block
        set_blk(64'h0, 4'd1, 4'd0, 32'h5500_0000);
        tick();
        set_blk(64'h100, 4'd2, 4'd1, 32'h5600_0000);
        #1;
        check("t5.none", 64'(bus.o_inst_vld), 64'h0);
        tick();
        idle();
        check("t5.lat", 64'(bus.o_inst_vld), 64'h0);
        tick();
        chk_grp("t5.g0", 4'h1, 64'h100, 3'd0, 32'h5600_0000, 4'd2);
        tick();
        check("t5.end", 64'(bus.o_inst_vld), 64'h0);

        // count clamp (12 -> 8) and PC wrap
        set_blk(64'hFFFF_FFFF_FFFF_FFF8, 4'd9, 4'd12, 32'h6600_0000);
        tick();
        idle();
        tick();
        chk_grp("t6.g0", 4'hF, 64'hFFFF_FFFF_FFFF_FFF8, 3'd0,
                32'h6600_0000, 4'd9);
        tick();
        chk_grp("t6.g1", 4'hF, 64'h8, 3'd4, 32'h6600_0000, 4'd9);
        tick();
        check("t6.end", 64'(bus.o_inst_vld), 64'h0);

        // reset mid-block while stalled, then resume
        set_blk(64'h7000, 4'd4, 4'd8, 32'h7700_0000);
        tick();
        idle();
        tick();
        check("t7.g0", 64'(bus.o_inst_vld), 64'hF);
        bus.i_stall = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t7.vld", 64'(bus.o_inst_vld), 64'h0);
        check("t7.pc", bus.o_pc[63:0], 64'h0);
        check("t7.inst", 64'(bus.o_inst[31:0]), 64'h0);
        check("t7.ftq", 64'(bus.o_ftqIdx), 64'h0);
        check("t7.rdy", 64'(bus.o_blk_rdy), 64'h0);
`ifdef FETCH_SENDER_PERF_EN
        check("t7.pstall", 64'(perf_stall), 64'h0);
`endif
        rst         = 1'b1;
        bus.i_stall = 1'b0;
        set_blk(64'h7800, 4'd5, 4'd3, 32'h7800_0000);
        tick();
        idle();
        tick();
        chk_grp("t7.res", 4'h7, 64'h7800, 3'd0, 32'h7800_0000, 4'd5);
        tick();
        check("t7.end", 64'(bus.o_inst_vld), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
